// File: rtl/exers_pkg.sv
// exers_pkg: shared types for the integer reservation station.
//   TAG_W          default operand tag width (ROB id)
//   XLEN           datapath width
//   alu_op_e       ALU op codes, shared with the ALU
//   exers_entry_t  one station entry
//   tag_hit()      CDB tag match on a not-ready operand
package exers_pkg;
  localparam int TAG_W = 8;
  localparam int XLEN  = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_LUI  = 5'd10
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    alu_op_e         op;
    logic [7:0]      robid;
    logic [5:0]      rd;
    logic            op1rdy;
    logic [XLEN-1:0] op1;
    logic            op2rdy;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
  } exers_entry_t;

  // Only the low tagw bits of a waiting operand carry the tag; a ready
  // operand holds data and must never match.
  function automatic logic tag_hit(input logic rdy, input logic [XLEN-1:0] opnd,
                                   input logic [TAG_W-1:0] tag, input int tagw);
    logic [XLEN-1:0] diff;
    diff    = opnd ^ XLEN'(tag);
    tag_hit = 1'b0;
    if (!rdy) begin
      tag_hit = 1'b1;
      for (int b = 0; b < TAG_W; b++)
        if (b < tagw && diff[b]) tag_hit = 1'b0;
    end
  endfunction
endpackage

// File: rtl/exers_select.sv
// exers_select: pick one requester from a ready vector.
//   i_rdy    ready vector
//   i_age    (EXERS_AGE_SELECT_EN only) i_age[i][j]=1: j is older than i
//   o_grant  one-hot grant
//   o_found  any requester ready
// Default build grants the lowest index; with EXERS_AGE_SELECT_EN it grants
// the ready requester with no older ready requester.
module exers_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]        i_rdy,
`ifdef EXERS_AGE_SELECT_EN
  input  logic [N-1:0][N-1:0] i_age,
`endif
  output logic [N-1:0]        o_grant,
  output logic                o_found
);
`ifdef EXERS_AGE_SELECT_EN
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < N; i++)
      o_grant[i] = i_rdy[i] & ~|(i_age[i] & i_rdy);
  end
`else
  // Isolate lowest set bit.
  assign o_grant = i_rdy & (~i_rdy + N'(1));
`endif
  assign o_found = |i_rdy;
endmodule

// File: rtl/exers.sv
// exers: integer execution reservation station.
//   clk, rst (sync, active-high)
//   rename_*            dispatch from rename; exers_stall when full
//   wb_valid/tag/value  CDB wakeup snoop
//   exers_issue_*       registered issue slot to the ALU; alu_stall holds it
//   rob_flush           clears all entries and the issue slot
// Option: EXERS_AGE_SELECT_EN selects oldest ready entry instead of lowest index.
module exers
  import exers_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAGW  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rename_exers_write,
  input  logic [4:0]  rename_op,
  input  logic [7:0]  rename_robid,
  input  logic [5:0]  rename_rd,
  input  logic        rename_op1ready,
  input  logic [31:0] rename_op1,
  input  logic        rename_op2ready,
  input  logic [31:0] rename_op2,
  input  logic [31:0] rename_imm,
  output logic        exers_stall,
  input  logic        wb_valid,
  input  logic [7:0]  wb_tag,
  input  logic [31:0] wb_value,
  input  logic        alu_stall,
  output logic        exers_issue_valid,
  output logic [4:0]  exers_issue_op,
  output logic [7:0]  exers_issue_robid,
  output logic [5:0]  exers_issue_rd,
  output logic [31:0] exers_issue_op1,
  output logic [31:0] exers_issue_op2,
  output logic [31:0] exers_issue_imm,
  input  logic        rob_flush
);
  exers_entry_t     r_ent [DEPTH];
  exers_entry_t     w_new;
  logic [DEPTH-1:0] w_vld, w_rdy, w_grant, w_alloc_oh;
  logic             w_found, w_alloc, w_load;
  logic [4:0]       w_sel_op;
  logic [7:0]       w_sel_robid;
  logic [5:0]       w_sel_rd;
  logic [31:0]      w_sel_op1, w_sel_op2, w_sel_imm;

  logic             r_iss_valid;
  logic [4:0]       r_iss_op;
  logic [7:0]       r_iss_robid;
  logic [5:0]       r_iss_rd;
  logic [31:0]      r_iss_op1, r_iss_op2, r_iss_imm;

  always_comb begin
    w_vld = '0;
    w_rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_vld[i] = r_ent[i].valid;
      w_rdy[i] = r_ent[i].valid & r_ent[i].op1rdy & r_ent[i].op2rdy;
    end
  end

  assign exers_stall = &w_vld;
  assign w_alloc     = rename_exers_write & ~exers_stall;
  // Lowest clear bit of the valid vector.
  assign w_alloc_oh  = ~w_vld & (w_vld + DEPTH'(1));
  // Slot accepts when empty or being consumed this cycle.
  assign w_load      = (~r_iss_valid | ~alu_stall) & w_found & ~rob_flush;

`ifdef EXERS_AGE_SELECT_EN
  // r_age[i][j]=1: entry j was resident when i was allocated (j older).
  // Allocating k clears column k so stale order from k's previous life dies.
  logic [DEPTH-1:0][DEPTH-1:0] r_age;

  always_ff @(posedge clk) begin
    if (rst) r_age <= '0;
    else if (w_alloc) begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (w_alloc_oh[i])      r_age[i][j] <= w_vld[j];
          else if (w_alloc_oh[j]) r_age[i][j] <= 1'b0;
    end
  end

  exers_select #(.N(DEPTH)) u_sel (
    .i_rdy(w_rdy), .i_age(r_age), .o_grant(w_grant), .o_found(w_found));
`else
  exers_select #(.N(DEPTH)) u_sel (
    .i_rdy(w_rdy), .o_grant(w_grant), .o_found(w_found));
`endif

  // Incoming entry, with same-cycle CDB bypass on waiting operands.
  always_comb begin
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.op     = alu_op_e'(rename_op);
    w_new.robid  = rename_robid;
    w_new.rd     = rename_rd;
    w_new.op1rdy = rename_op1ready;
    w_new.op1    = rename_op1;
    w_new.op2rdy = rename_op2ready;
    w_new.op2    = rename_op2;
    w_new.imm    = rename_imm;
    if (wb_valid && tag_hit(rename_op1ready, rename_op1, wb_tag, TAGW)) begin
      w_new.op1rdy = 1'b1;
      w_new.op1    = wb_value;
    end
    if (wb_valid && tag_hit(rename_op2ready, rename_op2, wb_tag, TAGW)) begin
      w_new.op2rdy = 1'b1;
      w_new.op2    = wb_value;
    end
  end

  always_comb begin
    w_sel_op    = '0;
    w_sel_robid = '0;
    w_sel_rd    = '0;
    w_sel_op1   = '0;
    w_sel_op2   = '0;
    w_sel_imm   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_grant[i]) begin
        w_sel_op    = r_ent[i].op;
        w_sel_robid = r_ent[i].robid;
        w_sel_rd    = r_ent[i].rd;
        w_sel_op1   = r_ent[i].op1;
        w_sel_op2   = r_ent[i].op2;
        w_sel_imm   = r_ent[i].imm;
      end
  end

  // Entry state: allocation targets a free entry, issue frees a ready one,
  // so the two never collide on the same index.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || rob_flush) r_ent[i].valid <= 1'b0;
      else if (w_alloc && w_alloc_oh[i]) r_ent[i] <= w_new;
      else if (r_ent[i].valid) begin
        if (w_load && w_grant[i]) r_ent[i].valid <= 1'b0;
        if (wb_valid && tag_hit(r_ent[i].op1rdy, r_ent[i].op1, wb_tag, TAGW)) begin
          r_ent[i].op1rdy <= 1'b1;
          r_ent[i].op1    <= wb_value;
        end
        if (wb_valid && tag_hit(r_ent[i].op2rdy, r_ent[i].op2, wb_tag, TAGW)) begin
          r_ent[i].op2rdy <= 1'b1;
          r_ent[i].op2    <= wb_value;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_robid <= '0;
      r_iss_rd    <= '0;
      r_iss_op1   <= '0;
      r_iss_op2   <= '0;
      r_iss_imm   <= '0;
    end else if (rob_flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_load) begin
      r_iss_valid <= 1'b1;
      r_iss_op    <= w_sel_op;
      r_iss_robid <= w_sel_robid;
      r_iss_rd    <= w_sel_rd;
      r_iss_op1   <= w_sel_op1;
      r_iss_op2   <= w_sel_op2;
      r_iss_imm   <= w_sel_imm;
    end else if (!alu_stall) begin
      r_iss_valid <= 1'b0;
    end
  end

  assign exers_issue_valid = r_iss_valid;
  assign exers_issue_op    = r_iss_op;
  assign exers_issue_robid = r_iss_robid;
  assign exers_issue_rd    = r_iss_rd;
  assign exers_issue_op1   = r_iss_op1;
  assign exers_issue_op2   = r_iss_op2;
  assign exers_issue_imm   = r_iss_imm;
endmodule
